reg_file_sb: RTL and testbench
==============================

// Module: reg_file_sb
// PURPOSE
//  Integer register file with scoreboard; consumer end of the writeback bus
//  (o_data/o_rd_id/o_valid of the WB stage land on i_wb_*). Serves operand
//  reads to the decode stage through a valid/ready handshake and holds back a
//  read while any source or destination register still has a write in flight.
//  Read data is registered: one-cycle response latency, same-cycle WB bypass.
// PARAMETERS
//  DATA_W   64  register width in bits
//  REG_N    32  number of architectural registers (x0 hardwired to zero)
//  ID_W     5   register index width, $clog2(REG_N)
// PORTS
//  i_clk         in   1       clock, rising edge
//  i_rst_n       in   1       reset, asynchronous, active-low
//  i_wb_valid    in   1       writeback strobe from WB stage
//  i_wb_rd_id    in   ID_W    writeback destination index
//  i_wb_data     in   DATA_W  writeback data
//  i_req_valid   in   1       decode presents an operand read request
//  o_req_ready   out  1       request accepted this cycle (combinational)
//  i_rs1_id      in   ID_W    source 1 index
//  i_rs2_id      in   ID_W    source 2 index
//  i_rd_id       in   ID_W    destination of the issuing instruction
//  i_rd_wen      in   1       issuing instruction will write i_rd_id
//  i_flush       in   1       drop pending response, clear scoreboard
//  o_rsp_valid   out  1       operand response valid (one-cycle pulse)
//  o_rs1_data    out  DATA_W  source 1 value
//  o_rs2_data    out  DATA_W  source 2 value
//  o_busy        out  1       any scoreboard bit set
// BEHAVIOUR
//  - Reset: all registers 0, all pending bits 0, o_rsp_valid 0, o_rs*_data 0.
//  - Write: on i_wb_valid && i_wb_rd_id!=0, reg[i_wb_rd_id]<=i_wb_data at the
//    clock edge and pending[i_wb_rd_id] cleared. Writes to x0 discarded.
//    Write to a non-pending register is still performed (untracked write).
//  - Effective pending p'[r] = pending[r] && !(i_wb_valid && i_wb_rd_id==r).
//  - Hazard = p'[rs1] | p'[rs2] | (i_rd_wen & p'[rd]); index 0 never hazards.
//  - o_req_ready = !hazard && !i_flush. Accept = i_req_valid && o_req_ready.
//  - On accept: o_rsp_valid<=1 next cycle; o_rsN_data<= value with bypass:
//    rsN==0 -> 0; i_wb_valid && i_wb_rd_id==rsN -> i_wb_data; else reg[rsN].
//    If i_rd_wen && rd!=0, pending[rd]<=1 (set wins over same-cycle clear).
//  - No accept: o_rsp_valid<=0; o_rs*_data hold last value.
//  - Decode must keep request fields stable while i_req_valid && !ready.
//  - i_flush: clears all pending bits and forces o_rsp_valid<=0 next cycle;
//    a same-cycle WB write still updates the array. No accept that cycle.
//  - o_busy = |pending (registered state, excludes same-cycle clear).
//  - Reset mid-operation: state returns to reset values immediately.
// TESTING
//  - Reset, read x1/x2 -> ready=1, next cycle rsp_valid=1, data 0/0.
//  - WB write x5=0x1234; next cycle read rs1=x5 -> o_rs1_data=0x1234.
//  - Same-cycle WB x7=0xAA and read rs2=x7 -> o_rs2_data=0xAA (bypass).
//  - Issue rd=x3 wen; then read rs1=x3 -> ready=0 until WB x3=0x55 cycle,
//    ready=1 in that cycle, response data 0x55; o_busy 1 then 0.
//  - WB write x0=0xFF, rd=x0 wen; read x0 -> data 0, never stalls, busy=0.
//  - Pending x4, assert i_flush -> pending cleared, no rsp; read x4 ready=1.

Source files
------------

// File: rtl/reg_file_sb.sv
// Integer register file with a per-register write-pending scoreboard.
// Operand reads are held back while a source or destination still awaits writeback.
module reg_file_sb #(
    parameter int DATA_W = 64,
    parameter int REG_N  = 32,
    parameter int ID_W   = $clog2(REG_N)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_wb_valid,
    input  logic [ID_W-1:0]   i_wb_rd_id,
    input  logic [DATA_W-1:0] i_wb_data,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ID_W-1:0]   i_rs1_id,
    input  logic [ID_W-1:0]   i_rs2_id,
    input  logic [ID_W-1:0]   i_rd_id,
    input  logic              i_rd_wen,
    input  logic              i_flush,
    output logic              o_rsp_valid,
    output logic [DATA_W-1:0] o_rs1_data,
    output logic [DATA_W-1:0] o_rs2_data,
    output logic              o_busy
);

    // Handshake: a request is taken in any cycle where i_req_valid && o_req_ready;
    // o_req_ready never depends on i_req_valid, and the response follows one cycle later.

    logic [DATA_W-1:0] regs_q [REG_N];
    logic [REG_N-1:0]  pending_q, pending_d;
    logic [REG_N-1:0]  wb_hit, p_eff, set_mask;
    logic              wb_we, hazard, accept;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [DATA_W-1:0] rs1_val, rs2_val;

    assign wb_we = i_wb_valid && (i_wb_rd_id != '0);

    always_comb begin
        wb_hit = '0;
        if (wb_we) wb_hit[i_wb_rd_id] = 1'b1;
        // A writeback landing this cycle already resolves its register.
        p_eff    = pending_q & ~wb_hit;
        p_eff[0] = 1'b0;
        hazard   = p_eff[i_rs1_id] | p_eff[i_rs2_id] | (i_rd_wen & p_eff[i_rd_id]);
    end

    assign o_req_ready = !hazard && !i_flush;
    assign accept      = i_req_valid && o_req_ready;

    always_comb begin
        rs1_val = regs_q[i_rs1_id];
        if (i_rs1_id == '0)                     rs1_val = '0;
        else if (wb_we && i_wb_rd_id == i_rs1_id) rs1_val = i_wb_data;
        rs2_val = regs_q[i_rs2_id];
        if (i_rs2_id == '0)                     rs2_val = '0;
        else if (wb_we && i_wb_rd_id == i_rs2_id) rs2_val = i_wb_data;
    end

    always_comb begin
        set_mask = '0;
        if (accept && i_rd_wen && i_rd_id != '0) set_mask[i_rd_id] = 1'b1;
        // Issue set wins over a same-cycle writeback clear of the same register.
        pending_d    = i_flush ? '0 : ((pending_q & ~wb_hit) | set_mask);
        pending_d[0] = 1'b0;
        rsp_valid_d  = accept;
        rs1_d        = accept ? rs1_val : rs1_q;
        rs2_d        = accept ? rs2_val : rs2_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < REG_N; i++) regs_q[i] <= '0;
        end else if (wb_we) begin
            regs_q[i_wb_rd_id] <= i_wb_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q   <= '0;
            rsp_valid_q <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            rsp_valid_q <= rsp_valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
        end
    end

    assign o_rsp_valid = rsp_valid_q;
    assign o_rs1_data  = rs1_q;
    assign o_rs2_data  = rs2_q;
    assign o_busy      = |pending_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a reference register/scoreboard model predicts ready,
// busy and every response; responses are checked against a FIFO of expectations.
module tb_reg_file_sb;
    localparam int DATA_W = 64;
    localparam int REG_N  = 32;
    localparam int ID_W   = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              wb_valid;
    logic [ID_W-1:0]   wb_rd_id;
    logic [DATA_W-1:0] wb_data;
    logic              req_valid;
    logic              req_ready;
    logic [ID_W-1:0]   rs1_id, rs2_id, rd_id;
    logic              rd_wen;
    logic              flush;
    logic              rsp_valid;
    logic [DATA_W-1:0] rs1_data, rs2_data;
    logic              busy;

    always #5 clk = ~clk;

    reg_file_sb #(.DATA_W(DATA_W), .REG_N(REG_N), .ID_W(ID_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_valid(wb_valid), .i_wb_rd_id(wb_rd_id), .i_wb_data(wb_data),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_rs1_id(rs1_id), .i_rs2_id(rs2_id), .i_rd_id(rd_id), .i_rd_wen(rd_wen),
        .i_flush(flush),
        .o_rsp_valid(rsp_valid), .o_rs1_data(rs1_data), .o_rs2_data(rs2_data),
        .o_busy(busy)
    );

    logic [DATA_W-1:0]   m_regs [REG_N];
    logic [REG_N-1:0]    m_pend;
    logic [2*DATA_W-1:0] exp_q [$];
    logic [2*DATA_W-1:0] last_exp;
    int vectors     = 0;
    int miscompares = 0;

    task automatic model_reset();
        for (int i = 0; i < REG_N; i++) m_regs[i] = '0;
        m_pend   = '0;
        exp_q.delete();
        last_exp = '0;
    endtask

    task automatic idle();
        wb_valid = 1'b0; wb_rd_id = '0; wb_data = '0;
        req_valid = 1'b0; rs1_id = '0; rs2_id = '0; rd_id = '0; rd_wen = 1'b0;
        flush = 1'b0;
    endtask

    function automatic logic [DATA_W-1:0] m_read(input logic [ID_W-1:0] id);
        if (id == '0) return '0;
        if (wb_valid && wb_rd_id == id) return wb_data;
        return m_regs[id];
    endfunction

    function automatic logic m_peff(input logic [ID_W-1:0] id);
        return (id != '0) && m_pend[id] && !(wb_valid && wb_rd_id == id);
    endfunction

    // One clock cycle: check outputs at the falling edge, advance the model,
    // then return just after the next rising edge with inputs still applied.
    task automatic step(output logic acc);
        logic exp_rv, exp_ready;
        @(negedge clk);
        exp_rv = 1'b0;
        if (exp_q.size() != 0) begin
            last_exp = exp_q.pop_front();
            exp_rv   = 1'b1;
        end
        vectors++;
        if (rsp_valid !== exp_rv) begin
            miscompares++;
            $display("FAIL rsp_valid: got %0b expected %0b @%0t", rsp_valid, exp_rv, $time);
        end
        vectors++;
        if ({rs1_data, rs2_data} !== last_exp) begin
            miscompares++;
            $display("FAIL rsp_data: got %h_%h expected %h @%0t", rs1_data, rs2_data, last_exp, $time);
        end
        vectors++;
        if (busy !== (|m_pend)) begin
            miscompares++;
            $display("FAIL busy: got %0b expected %0b @%0t", busy, |m_pend, $time);
        end
        exp_ready = !(m_peff(rs1_id) | m_peff(rs2_id) | (rd_wen & m_peff(rd_id))) && !flush;
        vectors++;
        if (req_ready !== exp_ready) begin
            miscompares++;
            $display("FAIL req_ready: got %0b expected %0b @%0t", req_ready, exp_ready, $time);
        end
        acc = req_valid && exp_ready;
        if (acc) exp_q.push_back({m_read(rs1_id), m_read(rs2_id)});
        if (wb_valid && wb_rd_id != '0) begin
            m_regs[wb_rd_id] = wb_data;
            m_pend[wb_rd_id] = 1'b0;
        end
        if (flush) m_pend = '0;
        else if (acc && rd_wen && rd_id != '0) m_pend[rd_id] = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [ID_W-1:0] a, input logic [ID_W-1:0] b,
                           input logic [ID_W-1:0] d, input logic we);
        req_valid = 1'b1; rs1_id = a; rs2_id = b; rd_id = d; rd_wen = we;
    endtask

    task automatic set_wb(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] d);
        wb_valid = 1'b1; wb_rd_id = id; wb_data = d;
    endtask

    task automatic test_reset();
        logic acc;
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rs1_data !== '0 || rs2_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got rsp=%0b busy=%0b d1=%h d2=%h expected all zero",
                     rsp_valid, busy, rs1_data, rs2_data);
        end
        rst_n = 1'b1;
        set_req(5'd1, 5'd2, 5'd0, 1'b0);
        step(acc);
        idle();
        step(acc);
    endtask

    task automatic test_wb_read();
        logic acc;
        set_wb(5'd5, 64'h1234);
        step(acc);
        idle();
        set_req(5'd5, 5'd0, 5'd0, 1'b0);
        step(acc);
        idle();
        step(acc);
    endtask

    task automatic test_bypass();
        logic acc;
        set_wb(5'd7, 64'hAA);
        set_req(5'd5, 5'd7, 5'd0, 1'b0);
        step(acc);
        idle();
        step(acc);
    endtask

    task automatic test_hazard();
        logic acc;
        set_req(5'd0, 5'd0, 5'd3, 1'b1);
        step(acc);
        set_req(5'd3, 5'd0, 5'd0, 1'b0);
        repeat (3) step(acc);
        set_wb(5'd3, 64'h55);
        step(acc);
        idle();
        repeat (2) step(acc);
    endtask

    task automatic test_x0();
        logic acc;
        set_wb(5'd0, 64'hFF);
        set_req(5'd0, 5'd0, 5'd0, 1'b1);
        step(acc);
        idle();
        set_req(5'd0, 5'd0, 5'd0, 1'b0);
        step(acc);
        idle();
        step(acc);
    endtask

    task automatic test_flush();
        logic acc;
        set_req(5'd0, 5'd0, 5'd4, 1'b1);
        step(acc);
        set_req(5'd4, 5'd0, 5'd0, 1'b0);
        flush = 1'b1;
        step(acc);
        flush = 1'b0;
        step(acc);
        idle();
        step(acc);
    endtask

    task automatic test_mid_reset();
        logic acc;
        set_wb(5'd9, 64'hDEAD_BEEF);
        set_req(5'd9, 5'd0, 5'd6, 1'b1);
        step(acc);
        idle();
        rst_n = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0 || rs1_data !== '0 || rs2_data !== '0) begin
            miscompares++;
            $display("FAIL mid_reset: got rsp=%0b busy=%0b d1=%h d2=%h expected all zero",
                     rsp_valid, busy, rs1_data, rs2_data);
        end
        model_reset();
        #1;
        rst_n = 1'b1;
        set_req(5'd9, 5'd6, 5'd0, 1'b0);
        step(acc);
        idle();
        step(acc);
    endtask

    task automatic test_back_to_back();
        logic acc;
        logic hold;
        set_wb(5'd1, 64'h1111);
        set_req(5'd1, 5'd2, 5'd0, 1'b0);
        step(acc);
        set_wb(5'd2, 64'h2222);
        set_req(5'd2, 5'd1, 5'd0, 1'b0);
        step(acc);
        wb_valid = 1'b0;
        set_req(5'd1, 5'd2, 5'd0, 1'b0);
        step(acc);
        hold = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if (!hold) begin
                req_valid = ($urandom_range(0, 3) != 0);
                rs1_id    = ID_W'($urandom_range(0, 7));
                rs2_id    = ID_W'($urandom_range(0, 7));
                rd_id     = ID_W'($urandom_range(0, 7));
                rd_wen    = $urandom_range(0, 1) == 1;
            end
            wb_valid = $urandom_range(0, 1) == 1;
            wb_rd_id = ID_W'($urandom_range(0, 7));
            wb_data  = {$urandom, $urandom};
            flush    = ($urandom_range(0, 19) == 0);
            step(acc);
            hold = req_valid && !acc;
        end
        idle();
        step(acc);
        step(acc);
    endtask

    initial begin
        test_reset();
        test_wb_read();
        test_bypass();
        test_hazard();
        test_x0();
        test_flush();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
